// File: rtl/register_inject_pkg.sv
// Shared types and widths for the register_inject writeback injector.
package register_inject_pkg;

    localparam int REG_ID_W = 5;
    localparam int DATA_W   = 32;
    localparam int HALF_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/register_inject_button_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted 0->1 transition of the debounced level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_count;
    logic             r_pulse;

    // The pulse is raised on the same edge that accepts a new high level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync   <= 2'b00;
            r_stable <= 1'b0;
            r_count  <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= 1'b0;
            if (r_sync[1] != r_stable) begin
                if (r_count == CNT_LAST) begin
                    r_stable <= r_sync[1];
                    r_count  <= '0;
                    r_pulse  <= r_sync[1];
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                r_count <= '0;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/register_inject.sv
// Switch/button driven writer for the core's register writeback bus.
// Optional grant-wait timeout is built when REGISTER_INJECT_TIMEOUT_EN is defined.
module register_inject
    import register_inject_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [HALF_W-1:0]   sw_data,
    input  logic                sw_upper,
    input  logic [REG_ID_W-1:0] sw_address,
    input  logic                btn_load,
    input  logic                btn_commit,
    input  logic                inject_grant,
    output logic                inject_req,
    output logic [DATA_W-1:0]   write_data,
    output logic [REG_ID_W-1:0] write_id,
    output logic                write_enable,
    output logic                busy,
    output logic [HALF_W-1:0]   staged_led,
    output logic                timeout_flag
);

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_staging;
    logic [DATA_W-1:0]   r_write_data;
    logic [REG_ID_W-1:0] r_write_id;
    logic                w_load_pulse;
    logic                w_commit_pulse;
    logic                w_load_go;
    logic                w_commit_go;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_load),
        .o_pulse (w_load_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_db (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_commit),
        .o_pulse (w_commit_pulse)
    );

    // Register x0 is hardwired in the core, so a commit aimed at it is ignored.
    assign w_load_go   = (r_state == IDLE) && w_load_pulse;
    assign w_commit_go = (r_state == IDLE) && w_commit_pulse && (sw_address != '0);

`ifdef REGISTER_INJECT_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] r_wait;
    logic              r_timeout_flag;
    logic              w_timeout_hit;

    assign w_timeout_hit = (r_state == REQ) && !inject_grant && (r_wait == WAIT_LAST);

    // A grant on the final wait cycle still wins over the abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait         <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == REQ) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (w_timeout_hit) begin
                r_timeout_flag <= 1'b1;
            end else if (r_state == WRITE) begin
                r_timeout_flag <= 1'b0;
            end
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_flag     = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_commit_go) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (inject_grant) begin
                    w_next_state = WRITE;
                end
`ifdef REGISTER_INJECT_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    w_next_state = IDLE;
                end
`endif
            end
            WRITE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Commit samples staging before a same-cycle load lands, via non-blocking order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_staging    <= '0;
            r_write_data <= '0;
            r_write_id   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_go) begin
                if (sw_upper) begin
                    r_staging[DATA_W-1:HALF_W] <= sw_data;
                end else begin
                    r_staging[HALF_W-1:0] <= sw_data;
                end
            end
            if (w_commit_go) begin
                r_write_data <= r_staging;
                r_write_id   <= sw_address;
            end
        end
    end

    assign inject_req   = (r_state == REQ);
    assign write_enable = (r_state == WRITE);
    assign busy         = (r_state != IDLE);
    assign write_data   = r_write_data;
    assign write_id     = r_write_id;
    assign staged_led   = sw_upper ? r_staging[DATA_W-1:HALF_W] : r_staging[HALF_W-1:0];

endmodule

// File: tb/tb_register_inject.sv
// Scoreboard bench for register_inject; write expectations are queued when a
// commit is pressed and checked when write_enable fires.
module tb_register_inject;

    localparam int DEB = 4;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw_data = '0;
    logic        sw_upper = 1'b0;
    logic [4:0]  sw_address = '0;
    logic        btn_load = 1'b0;
    logic        btn_commit = 1'b0;
    logic        inject_grant = 1'b0;
    logic        inject_req;
    logic [31:0] write_data;
    logic [4:0]  write_id;
    logic        write_enable;
    logic        busy;
    logic [15:0] staged_led;
    logic        timeout_flag;

    int totalChecks = 0;
    int badChecks = 0;
    int writeCount = 0;
    int expectedWrites = 0;
    int reqCycles = 0;
    logic prevWe = 1'b0;
    logic [36:0] expQ[$];
    logic [31:0] expStaging = '0;

    register_inject #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_data      (sw_data),
        .sw_upper     (sw_upper),
        .sw_address   (sw_address),
        .btn_load     (btn_load),
        .btn_commit   (btn_commit),
        .inject_grant (inject_grant),
        .inject_req   (inject_req),
        .write_data   (write_data),
        .write_id     (write_id),
        .write_enable (write_enable),
        .busy         (busy),
        .staged_led   (staged_led),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Let the previous release settle, press, hold until the pulse has been consumed, release.
    task automatic applyStimulus(input bit doLoad, input bit doCommit);
        tick(DEB + 3);
        btn_load   = doLoad;
        btn_commit = doCommit;
        tick(DEB + 3);
        btn_load   = 1'b0;
        btn_commit = 1'b0;
    endtask

    task automatic pushWrite(input logic [4:0] id);
        expQ.push_back({id, expStaging});
        expectedWrites++;
    endtask

    task automatic grantAfter(input int n);
        int waited;
        waited = 0;
        while (!inject_req && waited < 40) begin
            tick(1);
            waited++;
        end
        if (!inject_req) checkOutput("req wait", inject_req, 1);
        tick(n);
        inject_grant = 1'b1;
        tick(1);
        inject_grant = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (inject_req) reqCycles++;
            if (write_enable) begin
                writeCount++;
                checkOutput("we single cycle", prevWe, 0);
                checkOutput("req during write", inject_req, 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected write", write_enable, 0);
                end else begin
                    checkOutput("write id/data", {27'd0, write_id, write_data}, {27'd0, expQ.pop_front()});
                end
            end
        end
        prevWe = write_enable;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int reqBefore;

        // Reset state
        tick(3);
        checkOutput("rst inject_req", inject_req, 0);
        checkOutput("rst write_enable", write_enable, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst write_data", write_data, 0);
        checkOutput("rst write_id", write_id, 0);
        checkOutput("rst timeout_flag", timeout_flag, 0);
        checkOutput("rst staged lo", staged_led, 0);
        sw_upper = 1'b1;
        #1;
        checkOutput("rst staged hi", staged_led, 0);
        rst = 1'b1;
        tick(2);

        // Stage DEAD then BEEF, commit to x5, grant three cycles after request
        $display("[TB] stage and write");
        sw_upper = 1'b1; sw_data = 16'hDEAD;
        applyStimulus(1, 0);
        expStaging[31:16] = 16'hDEAD;
        sw_upper = 1'b0; sw_data = 16'hBEEF;
        applyStimulus(1, 0);
        expStaging[15:0] = 16'hBEEF;
        #1;
        checkOutput("staged lo", staged_led, expStaging[15:0]);
        sw_upper = 1'b1;
        #1;
        checkOutput("staged hi", staged_led, expStaging[31:16]);
        sw_address = 5'd5;
        pushWrite(5'd5);
        applyStimulus(0, 1);
        checkOutput("req after commit", inject_req, 1);
        checkOutput("busy in req", busy, 1);
        tick(2);
        inject_grant = 1'b1;
        checkOutput("no we before grant", write_enable, 0);
        tick(1);
        inject_grant = 1'b0;
        checkOutput("we after grant", write_enable, 1);
        tick(1);
        checkOutput("we dropped", write_enable, 0);
        checkOutput("busy after write", busy, 0);
        checkOutput("write_data held", write_data, 32'hDEADBEEF);

        // Bouncing commit, then a clean high level
        $display("[TB] bounce");
        sw_address = 5'd3;
        tick(DEB + 3);
        reqBefore = reqCycles;
        for (int i = 0; i < 10; i++) begin
            btn_commit = (i % 2 == 0);
            tick(2);
        end
        checkOutput("bounce no req", reqCycles - reqBefore, 0);
        pushWrite(5'd3);
        btn_commit = 1'b1;
        n = 0;
        while (!inject_req && n < 30) begin
            tick(1);
            n++;
        end
        // pulse after DEB+2 edges, FSM enters REQ one edge later
        checkOutput("bounce latency", n, DEB + 3);
        btn_commit = 1'b0;
        grantAfter(0);
        tick(2);

        // Commit to x0 is ignored even with grant held high
        $display("[TB] address x0");
        sw_address = 5'd0;
        inject_grant = 1'b1;
        reqBefore = reqCycles;
        applyStimulus(0, 1);
        tick(4);
        checkOutput("x0 req cycles", reqCycles - reqBefore, 0);
        checkOutput("x0 busy", busy, 0);
        inject_grant = 1'b0;

        // Load while busy is dropped
        $display("[TB] busy drop");
        sw_address = 5'd6;
        pushWrite(5'd6);
        applyStimulus(0, 1);
        sw_upper = 1'b0; sw_data = 16'h1234;
        btn_load = 1'b1;
        tick(DEB + 3);
        btn_load = 1'b0;
        checkOutput("busy during load", busy, 1);
        checkOutput("staging frozen", staged_led, expStaging[15:0]);
        inject_grant = 1'b1;
        tick(1);
        inject_grant = 1'b0;
        tick(2);
        checkOutput("staging after drop", staged_led, expStaging[15:0]);
`ifndef REGISTER_INJECT_TIMEOUT_EN
        sw_address = 5'd8;
        pushWrite(5'd8);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        grantAfter(1);
        tick(2);
        checkOutput("idle after dropped commit", busy, 0);
`endif

        // Load and commit in the same cycle
        $display("[TB] simultaneous load and commit");
        sw_upper = 1'b1; sw_data = 16'h5555; sw_address = 5'd7;
        pushWrite(5'd7);
        applyStimulus(1, 1);
        expStaging[31:16] = 16'h5555;
        grantAfter(1);
        tick(2);
        checkOutput("staging after simul", staged_led, expStaging[31:16]);

`ifdef REGISTER_INJECT_TIMEOUT_EN
        $display("[TB] timeout");
        sw_address = 5'd10;
        applyStimulus(0, 1);
        n = inject_req ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!inject_req) break;
            n++;
        end
        checkOutput("timeout req cycles", n, TO);
        checkOutput("timeout flag set", timeout_flag, 1);
        checkOutput("timeout idle", busy, 0);
        sw_address = 5'd11;
        pushWrite(5'd11);
        applyStimulus(0, 1);
        checkOutput("flag sticky", timeout_flag, 1);
        grantAfter(0);
        tick(2);
        checkOutput("flag cleared", timeout_flag, 0);
`endif

        // Reset while requesting
        $display("[TB] reset mid-request");
        sw_address = 5'd9;
        applyStimulus(0, 1);
        checkOutput("req before reset", inject_req, 1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        checkOutput("req after reset", inject_req, 0);
        checkOutput("busy after reset", busy, 0);
        checkOutput("data after reset", write_data, 0);
        checkOutput("id after reset", write_id, 0);
        checkOutput("flag after reset", timeout_flag, 0);
        sw_upper = 1'b0;
        #1;
        checkOutput("staged lo after reset", staged_led, 0);
        sw_upper = 1'b1;
        #1;
        checkOutput("staged hi after reset", staged_led, 0);
        inject_grant = 1'b1;
        tick(DEB * 4);
        inject_grant = 1'b0;
        tick(2);

        checkOutput("write count", writeCount, expectedWrites);
        checkOutput("queue drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/register_inject.md
Name: register_inject

Overview:
- Board-side writer that drives the core's register writeback interface (write_data / write_id / write_enable) from switches and buttons.
- The operator stages a 32-bit value 16 bits at a time, selects a destination register, and commits it.
- The block requests a writeback slot from the core, then issues a single-cycle write.
- It is the counterpart of the LED register-capture path: the same writeback bus, driven instead of snooped.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a button level is accepted.
- TIMEOUT_CYCLES, 1024: grant wait limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- sw_data  in  16  half-word to stage
- sw_upper  in  1  1 = load into staging[31:16], 0 = load into staging[15:0]
- sw_address  in  5  destination register index
- btn_load  in  1  raw, asynchronous button: stage sw_data
- btn_commit  in  1  raw, asynchronous button: issue write
- inject_grant  in  1  core: writeback slot free this cycle
- inject_req  out  1  request writeback slot
- write_data  out  32  value to write
- write_id  out  5  destination register
- write_enable  out  1  single-cycle write strobe
- busy  out  1  high in REQ or WRITE
- staged_led  out  16  staging half selected by sw_upper (combinational)
- timeout_flag  out  1  sticky abort flag

Behaviour:
- Reset (rst=0 at a clk edge):
  - staging=0, state=IDLE, inject_req=0, write_enable=0, write_data=0, write_id=0, timeout_flag=0.
  - Debouncers clear to stable=0 and count=0.
  - Reset mid-transaction abandons it; no write_enable is emitted.
- Button conditioning, per button:
  - 2-flop synchroniser.
  - Counter increments while the synchronised level differs from the stable level and clears otherwise.
  - When count reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - A stable 0->1 transition produces a 1-cycle press pulse.
  - Total latency from raw press to pulse: 2 + DEBOUNCE_CYCLES cycles.
- Load:
  - On a load pulse in IDLE, sw_upper selects the half that takes sw_data; the other half is unchanged.
  - Load pulses in REQ or WRITE are dropped; staging is frozen while busy.
- FSM IDLE -> REQ:
  - Transition occurs on a commit pulse in IDLE with sw_address != 0.
  - write_data <= staging and write_id <= sw_address are latched at that edge.
  - A commit with sw_address==0 is ignored; x0 is never written.
- REQ:
  - inject_req=1.
  - When inject_grant=1, the next state is WRITE.
- WRITE:
  - write_enable=1 for exactly one cycle; inject_req=0.
  - Next state is IDLE.
  - write_data and write_id hold their values until the next commit.
- Simultaneous events:
  - A load and a commit pulse in the same IDLE cycle: the commit latches the pre-load staging, and the load still updates staging.
  - Commit pulses while busy are dropped; there is no queueing.
- inject_grant is ignored outside REQ.

Optional Feature:
- Macro: REGISTER_INJECT_TIMEOUT_EN.
- With the macro defined:
  - A wait counter runs in REQ.
  - If inject_grant has not arrived after TIMEOUT_CYCLES cycles, the FSM returns to IDLE without writing and sets timeout_flag.
  - timeout_flag clears only on reset or on the next successful WRITE.
- Without the macro: REQ waits indefinitely, timeout_flag is tied to 0, and no counter is built.

Decomposition:
- Package register_inject_pkg:
  - state enum (IDLE, REQ, WRITE)
  - REG_ID_W=5, DATA_W=32, HALF_W=16
- Sub-module button_debounce (synchroniser + counter + edge pulse; parameter DEBOUNCE_CYCLES), instantiated once for btn_load and once for btn_commit.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8):
- Stage and write:
  - Stimulus: sw_upper=1, sw_data=16'hDEAD, press load; sw_upper=0, sw_data=16'hBEEF, press load; sw_address=5, press commit; grant 3 cycles after inject_req.
  - Required response: exactly one write_enable pulse, one cycle after grant, with write_id=5 and write_data=32'hDEADBEEF.
- Bounce:
  - Stimulus: btn_commit toggling every 2 cycles for 20 cycles, then held high.
  - Required response: exactly one commit pulse, 6 cycles after the stable high begins.
- Address x0:
  - Stimulus: sw_address=0, press commit.
  - Required response: inject_req and write_enable stay 0, busy stays 0.
- Busy drop:
  - Stimulus: while in REQ with grant held low, press load with 16'h1234 and press commit again; then grant.
  - Required response: one write of the original data; staging unchanged.
- Reset mid-REQ:
  - Stimulus: drive rst=0 for 1 cycle while inject_req=1.
  - Required response: next cycle inject_req=0, staging=0, and no write_enable ever fires.
- Timeout (with REGISTER_INJECT_TIMEOUT_EN):
  - Stimulus: commit with grant never asserted.
  - Required response: after 8 REQ cycles, return to IDLE with timeout_flag=1; a subsequent granted write clears it.
